// File: rtl/exc_pkg.sv
// Shared definitions for the precise-exception controller: ExcCodes, FSM states,
// CP0 register indices and the priority-slot-to-ExcCode mapping.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int CP0_BADVADDR = 8;
    localparam int CP0_STATUS   = 12;
    localparam int CP0_CAUSE    = 13;
    localparam int CP0_EPC      = 14;

    typedef enum logic [1:0] {
        IDLE,
        LOG,
        ERET_CLR,
        REDIRECT
    } exc_state_t;

    // Slot 0 is the highest priority (interrupt), slot 7 the lowest (AdES).
    function automatic logic [4:0] prio_code(input logic [2:0] slot);
        case (slot)
            3'd0:    prio_code = EXC_INT;
            3'd1:    prio_code = EXC_ADEL;
            3'd2:    prio_code = EXC_RI;
            3'd3:    prio_code = EXC_OV;
            3'd4:    prio_code = EXC_SYS;
            3'd5:    prio_code = EXC_BP;
            3'd6:    prio_code = EXC_ADEL;
            default: prio_code = EXC_ADES;
        endcase
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks the highest-priority pending cause and
// reports its ExcCode, whether it is an address error, and whether it is a fetch fault.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic       int_pend,
    input  logic       adel_if,
    input  logic       ri,
    input  logic       ov,
    input  logic       sys,
    input  logic       bp,
    input  logic       adel_d,
    input  logic       ades,
    output logic       hit,
    output logic [4:0] code,
    output logic       is_addr_err,
    output logic       is_fetch
);

    logic [7:0] req;
    logic [2:0] sel;

    assign req = {ades, adel_d, bp, sys, ov, ri, adel_if, int_pend};

    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                sel = 3'(i);
            end
        end
    end

    always_comb begin
        hit         = |req;
        code        = 5'd0;
        is_addr_err = 1'b0;
        is_fetch    = 1'b0;
        if (hit) begin
            code        = prio_code(sel);
            is_addr_err = (sel == 3'd1) || (sel == 3'd6) || (sel == 3'd7);
            is_fetch    = (sel == 3'd1);
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Precise exception / interrupt controller beside the MEM stage: logs the winning cause
// into CP0, flushes the pipe and redirects fetch. Optional macro: EXC_TIMER_INT_EN.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic [WIDTH-1:0] mem_pc,
    input  logic             mem_in_ds,
    input  logic             exc_adel_if,
    input  logic             exc_ri,
    input  logic             exc_ov,
    input  logic             exc_sys,
    input  logic             exc_bp,
    input  logic             exc_adel_d,
    input  logic             exc_ades,
    input  logic             is_eret,
    input  logic [WIDTH-1:0] mem_badvaddr,
    input  logic [5:0]       hw_int,
`ifdef EXC_TIMER_INT_EN
    input  logic             timer_int,
`endif
    input  logic [WIDTH-1:0] cp0_status,
    input  logic [WIDTH-1:0] cp0_cause,
    input  logic [WIDTH-1:0] cp0_epc,
    output logic [WIDTH-1:0] cp0_we,
    output logic [4:0]       cp0_exc_code,
    output logic [WIDTH-1:0] cp0_epc_o,
    output logic [WIDTH-1:0] cp0_badvaddr_o,
    output logic             cp0_bd,
    output logic             cp0_exl,
    output logic             cp0_ie,
    output logic             exc_hit,
    output logic             flush,
    output logic             stall,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc
);

    exc_state_t       state_reg, state_next;
    logic [5:0]       hw_int_src;
    logic [5:0]       hw_int_reg;
    logic             int_pend;
    logic             hit, is_addr_err, is_fetch;
    logic [4:0]       code;
    logic             take_exc, take_eret;

    logic [4:0]       code_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] badvaddr_reg;
    logic             bd_reg;
    logic             addr_err_reg;
    logic             eret_reg;

`ifdef EXC_TIMER_INT_EN
    assign hw_int_src = {hw_int[5] | timer_int, hw_int[4:0]};
`else
    assign hw_int_src = hw_int;
`endif

    // IM[15:8] masks {IP7..IP2 (hardware), IP1..IP0 (software)}.
    assign int_pend = cp0_status[0] & ~cp0_status[1]
                    & |(cp0_status[15:8] & {hw_int_reg, cp0_cause[9:8]});

    exc_prio_enc u_prio (
        .int_pend    (int_pend),
        .adel_if     (exc_adel_if),
        .ri          (exc_ri),
        .ov          (exc_ov),
        .sys         (exc_sys),
        .bp          (exc_bp),
        .adel_d      (exc_adel_d),
        .ades        (exc_ades),
        .hit         (hit),
        .code        (code),
        .is_addr_err (is_addr_err),
        .is_fetch    (is_fetch)
    );

    assign take_exc  = (state_reg == IDLE) && mem_valid && hit;
    assign take_eret = (state_reg == IDLE) && mem_valid && is_eret && !hit;
    assign exc_hit   = !rst && (take_exc || take_eret);

    logic unused_bits;
    assign unused_bits = ^{cp0_status[WIDTH-1:16], cp0_status[7:2],
                           cp0_cause[WIDTH-1:10], cp0_cause[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            hw_int_reg   <= '0;
            code_reg     <= '0;
            pc_reg       <= '0;
            badvaddr_reg <= '0;
            bd_reg       <= 1'b0;
            addr_err_reg <= 1'b0;
            eret_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hw_int_reg <= hw_int_src;
            if (take_exc) begin
                code_reg     <= code;
                pc_reg       <= mem_pc;
                badvaddr_reg <= is_fetch ? mem_pc : mem_badvaddr;
                bd_reg       <= mem_in_ds;
                addr_err_reg <= is_addr_err;
                eret_reg     <= 1'b0;
            end else if (take_eret) begin
                eret_reg     <= 1'b1;
            end
            // The return target is sampled from CP0 one cycle after ERET is seen.
            if (state_reg == ERET_CLR) begin
                pc_reg <= cp0_epc;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cp0_we         = '0;
        cp0_exc_code   = '0;
        cp0_epc_o      = '0;
        cp0_badvaddr_o = '0;
        cp0_bd         = 1'b0;
        cp0_exl        = 1'b0;
        cp0_ie         = 1'b0;
        flush          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_reg)
            IDLE: begin
                if (take_exc) begin
                    state_next = LOG;
                end else if (take_eret) begin
                    state_next = ERET_CLR;
                end
            end
            LOG: begin
                cp0_we[CP0_STATUS]   = 1'b1;
                cp0_we[CP0_CAUSE]    = 1'b1;
                cp0_we[CP0_EPC]      = 1'b1;
                cp0_we[CP0_BADVADDR] = addr_err_reg;
                cp0_exc_code         = code_reg;
                cp0_epc_o            = pc_reg;
                cp0_badvaddr_o       = badvaddr_reg;
                cp0_bd               = bd_reg;
                cp0_exl              = 1'b1;
                cp0_ie               = cp0_status[0];
                flush                = 1'b1;
                stall                = 1'b1;
                state_next           = REDIRECT;
            end
            ERET_CLR: begin
                cp0_we[CP0_STATUS] = 1'b1;
                cp0_ie             = cp0_status[0];
                flush              = 1'b1;
                stall              = 1'b1;
                state_next         = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = eret_reg ? pc_reg : EXC_VECTOR;
                stall          = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized self-checking bench for exc_ctrl against a cause-table reference model.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_in_ds, is_eret;
    logic [31:0] mem_pc, mem_badvaddr;
    logic        exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_d, exc_ades;
    logic [5:0]  hw_int;
    logic        timer_int;
    logic [31:0] cp0_status, cp0_cause, cp0_epc;
    logic [31:0] cp0_we, cp0_epc_o, cp0_badvaddr_o, redirect_pc;
    logic [4:0]  cp0_exc_code;
    logic        cp0_bd, cp0_exl, cp0_ie, exc_hit, flush, stall, redirect_valid;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

`ifdef EXC_TIMER_INT_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    // ExcCode of each synchronous cause, listed from highest to lowest priority:
    // AdEL-fetch, RI, Ov, Sys, Bp, AdEL-data, AdES.
    int codes[7] = '{4, 10, 12, 8, 9, 4, 5};

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_pc         (mem_pc),
        .mem_in_ds      (mem_in_ds),
        .exc_adel_if    (exc_adel_if),
        .exc_ri         (exc_ri),
        .exc_ov         (exc_ov),
        .exc_sys        (exc_sys),
        .exc_bp         (exc_bp),
        .exc_adel_d     (exc_adel_d),
        .exc_ades       (exc_ades),
        .is_eret        (is_eret),
        .mem_badvaddr   (mem_badvaddr),
        .hw_int         (hw_int),
`ifdef EXC_TIMER_INT_EN
        .timer_int      (timer_int),
`endif
        .cp0_status     (cp0_status),
        .cp0_cause      (cp0_cause),
        .cp0_epc        (cp0_epc),
        .cp0_we         (cp0_we),
        .cp0_exc_code   (cp0_exc_code),
        .cp0_epc_o      (cp0_epc_o),
        .cp0_badvaddr_o (cp0_badvaddr_o),
        .cp0_bd         (cp0_bd),
        .cp0_exl        (cp0_exl),
        .cp0_ie         (cp0_ie),
        .exc_hit        (exc_hit),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_flags(input logic [6:0] f);
        {exc_ades, exc_adel_d, exc_bp, exc_sys, exc_ov, exc_ri, exc_adel_if} = f;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_we"}, cp0_we, 32'h0);
        check_val({tag, "_flush"}, {31'b0, flush}, 32'h0);
        check_val({tag, "_stall"}, {31'b0, stall}, 32'h0);
        check_val({tag, "_rv"}, {31'b0, redirect_valid}, 32'h0);
        check_val({tag, "_rpc"}, redirect_pc, 32'h0);
    endtask

    // f bit order: [0] AdEL-fetch .. [6] AdES, matching the codes table.
    task automatic run_txn(input logic v, input logic [6:0] f, input logic er, input logic ds,
                           input logic [31:0] pc, input logic [31:0] bva, input logic [31:0] st,
                           input logic [31:0] ca, input logic [31:0] ep, input logic [5:0] hw,
                           input logic tmr);
        logic [5:0]  hw_eff;
        logic        pend, ip, ev_exc, ev_eret, addr, fetch;
        int          first;
        logic [4:0]  ecode;
        logic [31:0] ewe;

        hw_eff    = hw;
        hw_eff[5] = hw[5] | (tmr & TIMER_ON);
        pend = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (st[8+i] && ((i < 2) ? ca[8+i] : hw_eff[i-2])) pend = 1'b1;
        end
        ip = st[0] && !st[1] && pend;
        first = -1;
        for (int i = 6; i >= 0; i--) if (f[i]) first = i;
        ev_exc  = v && (ip || first >= 0);
        ev_eret = v && !ev_exc && er;
        ecode   = ip ? 5'd0 : (first >= 0 ? 5'(codes[first]) : 5'd0);
        addr    = !ip && first >= 0 && (codes[first] == 4 || codes[first] == 5);
        fetch   = !ip && first == 0;
        ewe     = 32'h0000_7000 | (addr ? 32'h0000_0100 : 32'h0);

        n_txn++;
        $display("txn %0d: v=%0b flags=%b eret=%0b ds=%0b pc=%h st=%h hw=%b int=%0b -> %s code=%0h",
                 n_txn, v, f, er, ds, pc, st, hw, ip,
                 ev_exc ? "exception" : (ev_eret ? "eret" : "none"), ecode);

        @(negedge clk);
        hw_int = hw; timer_int = tmr; cp0_status = st; cp0_cause = ca; cp0_epc = ep;
        mem_valid = 1'b0; set_flags(7'b0); is_eret = 1'b0;
        @(negedge clk);
        mem_valid = v; set_flags(f); is_eret = er; mem_in_ds = ds;
        mem_pc = pc; mem_badvaddr = bva;
        #1;
        check_val("exc_hit", {31'b0, exc_hit}, {31'b0, ev_exc | ev_eret});

        @(negedge clk);
        if (!(ev_exc || ev_eret)) begin
            mem_valid = 1'b0;
            #1;
            check_val("none_we", cp0_we, 32'h0);
            check_val("none_stall", {31'b0, stall}, 32'h0);
            return;
        end
        // Inputs churn while busy; none of it may disturb the event in flight.
        mem_valid = 1'b1; set_flags(7'($urandom)); is_eret = 1'($urandom);
        hw_int = 6'($urandom); mem_pc = $urandom; mem_badvaddr = $urandom;
        #1;
        check_val("busy_hit", {31'b0, exc_hit}, 32'h0);
        check_val("n1_flush", {31'b0, flush}, 32'h1);
        check_val("n1_stall", {31'b0, stall}, 32'h1);
        check_val("n1_rv", {31'b0, redirect_valid}, 32'h0);
        check_val("n1_ie", {31'b0, cp0_ie}, {31'b0, st[0]});
        if (ev_exc) begin
            check_val("log_we", cp0_we, ewe);
            check_val("log_code", {27'b0, cp0_exc_code}, {27'b0, ecode});
            check_val("log_exl", {31'b0, cp0_exl}, 32'h1);
            check_val("log_bd", {31'b0, cp0_bd}, {31'b0, ds});
            check_val("log_epc", cp0_epc_o, pc);
            if (addr) check_val("log_bva", cp0_badvaddr_o, fetch ? pc : bva);
        end else begin
            check_val("eret_we", cp0_we, 32'h0000_1000);
            check_val("eret_exl", {31'b0, cp0_exl}, 32'h0);
        end

        @(negedge clk);
        mem_valid = 1'b0; set_flags(7'b0); is_eret = 1'b0;
        #1;
        check_val("n2_rv", {31'b0, redirect_valid}, 32'h1);
        check_val("n2_rpc", redirect_pc, ev_exc ? 32'hBFC0_0380 : ep);
        check_val("n2_we", cp0_we, 32'h0);
        check_val("n2_stall", {31'b0, stall}, 32'h1);

        @(negedge clk);
        #1;
        check_quiet("n3");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_valid = 1'b0; mem_in_ds = 1'b0; is_eret = 1'b0;
        mem_pc = '0; mem_badvaddr = '0; hw_int = '0; timer_int = 1'b0;
        cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
        set_flags(7'b0);
        repeat (3) @(negedge clk);
        #1;
        check_quiet("rst");
        check_val("rst_hit", {31'b0, exc_hit}, 32'h0);
        check_val("rst_code", {27'b0, cp0_exc_code}, 32'h0);
        check_val("rst_epc", cp0_epc_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_txn(1'b1, 7'b1000000, 1'b0, 1'b0, 32'h8000_0100, 32'h0000_1003,
                32'h0, 32'h0, 32'h0, 6'h0, 1'b0);
        run_txn(1'b1, 7'b0001000, 1'b0, 1'b1, 32'h8000_0204, 32'h0,
                32'h0, 32'h0, 32'h0, 6'h0, 1'b0);
        run_txn(1'b1, 7'b0000100, 1'b0, 1'b0, 32'h8000_0300, 32'h0,
                32'h0000_0401, 32'h0, 32'h0, 6'h01, 1'b0);
        run_txn(1'b1, 7'b0, 1'b1, 1'b0, 32'h8000_0400, 32'h0,
                32'h0000_0003, 32'h0, 32'h8000_0040, 6'h0, 1'b0);
        run_txn(1'b1, 7'b0, 1'b0, 1'b0, 32'h8000_0500, 32'h0,
                32'h0000_0403, 32'h0, 32'h0, 6'h01, 1'b0);
        run_txn(1'b1, 7'b0000001, 1'b0, 1'b0, 32'h8000_0600, 32'h0000_0777,
                32'h0, 32'h0, 32'h0, 6'h0, 1'b0);
        run_txn(1'b1, 7'b0100000, 1'b1, 1'b0, 32'h8000_0700, 32'h0000_0888,
                32'h0, 32'h0, 32'h8000_0040, 6'h0, 1'b0);

        // Reset pulse while the controller sits in LOG.
        n_txn++;
        $display("txn %0d: reset pulsed during LOG of an AdES event", n_txn);
        @(negedge clk);
        cp0_status = '0; hw_int = '0;
        mem_valid = 1'b1; set_flags(7'b1000000); mem_pc = 32'h8000_0100; mem_badvaddr = 32'h1003;
        @(negedge clk);
        mem_valid = 1'b0; set_flags(7'b0);
        rst = 1'b1;
        #1;
        check_quiet("rstlog");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_val("rstlog_rv", {31'b0, redirect_valid}, 32'h0);
            check_val("rstlog_we", cp0_we, 32'h0);
            @(negedge clk);
        end

        for (int t = 0; t < 300; t++) begin
            logic [6:0]  f;
            logic [31:0] st;
            for (int b = 0; b < 7; b++) f[b] = ($urandom_range(0, 9) == 0);
            st    = $urandom;
            st[1] = ($urandom_range(0, 3) == 0);
            run_txn(($urandom_range(0, 7) != 0), f, ($urandom_range(0, 3) == 0),
                    1'($urandom), $urandom, $urandom, st, $urandom, $urandom,
                    6'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
